hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Pipeline hazard and stall sequencer for the 5-stage MIPS core.
//   - Detects load-use hazards and inserts one ID/EX bubble.
//   - Flushes IF/ID on a taken branch or jump.
//   - Freezes the whole pipeline while a data-memory access waits for its ack.
//   - Drives PC/IF-ID write enables and the control-zeroing mux that feeds the 8-bit ID/EX control bundle.
// PARAMETERS
//   MEM_TIMEOUT  255  max MEM_WAIT cycles before forced release (1..255)
//   CNT_W        16   width of performance counters (HAZARD_PERF_CNT_EN only)
// PORTS
//   clk_i          in   1      clock, rising edge
//   rst_i          in   1      reset, asynchronous, active-low
//   IFID_Rs_i      in   5      rs field of instruction in ID
//   IFID_Rt_i      in   5      rt field of instruction in ID
//   IDEX_Rt_i      in   5      rt (load destination) of instruction in EX
//   IDEX_MemRead_i in   1      instruction in EX is lw
//   Branch_i       in   1      branch resolved taken in ID
//   Jump_i         in   1      jump decoded in ID
//   DmemReq_i      in   1      MEM stage issues a data-memory access
//   DmemAck_i      in   1      data memory completes the access this cycle
//   PCWrite_o      out  1      PC register load enable
//   IFIDWrite_o    out  1      IF/ID register load enable
//   IFIDFlush_o    out  1      clear IF/ID to nop
//   IDEXBubble_o   out  1      select 8'h00 control bundle into ID/EX
//   Freeze_o       out  1      hold ID/EX, EX/MEM and MEM/WB registers
//   MemTimeout_o   out  1      sticky: a memory access timed out
//   StallCnt_o     out  CNT_W  stall-cycle count
//   FlushCnt_o     out  CNT_W  flush count
// BEHAVIOUR
//   FSM states: RUN, MEM_WAIT. 8-bit wait counter wcnt.
//   - Reset (rst_i=0): state=RUN, wcnt=0, MemTimeout_o=0, counters=0.
//   - Outputs while in reset: PCWrite_o=IFIDWrite_o=0, all others 0.
//   Output terms (all combinational from state and inputs; 0-cycle latency):
//   - mwait = (state==MEM_WAIT) | (state==RUN & DmemReq_i & ~DmemAck_i).
//   - lu = IDEX_MemRead_i & IDEX_Rt_i!=0 & (IDEX_Rt_i==IFID_Rs_i | IDEX_Rt_i==IFID_Rt_i).
//   Output equations (priority mwait > lu > flush):
//   - Freeze_o = mwait & ~DmemAck_i.
//   - PCWrite_o = IFIDWrite_o = ~Freeze_o & ~lu.
//   - IDEXBubble_o = ~Freeze_o & lu.
//   - IFIDFlush_o = ~Freeze_o & ~lu & (Branch_i | Jump_i).
//   Load-use and branch interaction:
//   - A branch depending on a load stalls first; branch is re-evaluated next cycle.
//   Transitions:
//   - RUN -> MEM_WAIT when DmemReq_i & ~DmemAck_i. Set wcnt=1.
//   - MEM_WAIT: DmemAck_i=1 -> RUN. Freeze drops in the ack cycle.
//   - MEM_WAIT: else wcnt==MEM_TIMEOUT -> RUN, MemTimeout_o<=1, freeze released.
//   - MEM_WAIT: else wcnt<=wcnt+1.
//   - DmemReq_i & DmemAck_i in the same cycle in RUN: no freeze, stay in RUN.
//   - MemTimeout_o clears only on reset.
//   - Reset asserted mid-MEM_WAIT: immediate return to RUN, wcnt=0.
// CONFIGURATION
//   HAZARD_PERF_CNT_EN defined:
//   - StallCnt_o +1 on each cycle with Freeze_o|IDEXBubble_o.
//   - FlushCnt_o +1 on each cycle with IFIDFlush_o.
//   - Both saturate at all-ones. No wrap.
//   HAZARD_PERF_CNT_EN undefined:
//   - Counter logic is not built. StallCnt_o and FlushCnt_o are tied to 0.
//   - Ports are kept so the interface is unchanged.
// TESTING
//   1 Load-use: IDEX_MemRead_i=1, IDEX_Rt_i=8, IFID_Rs_i=8
//     -> that cycle PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1.
//     -> next cycle with IDEX_MemRead_i=0: PCWrite_o=1.
//   2 No hazard on $zero: IDEX_Rt_i=0, IFID_Rt_i=0, IDEX_MemRead_i=1
//     -> IDEXBubble_o=0, PCWrite_o=1.
//   3 Branch vs load-use: Branch_i=1 with a load-use hazard
//     -> IFIDFlush_o=0 and bubble asserted.
//     -> next cycle hazard gone: IFIDFlush_o=1 for 1 cycle.
//   4 Memory wait: DmemReq_i=1, DmemAck_i low 3 cycles then high
//     -> Freeze_o=1 for 3 cycles, 0 in the ack cycle, state back to RUN.
//   5 Timeout (MEM_TIMEOUT=4): DmemReq_i=1, DmemAck_i never asserted
//     -> Freeze_o=1 for 4 cycles, then Freeze_o=0 and MemTimeout_o=1 held until reset.
//   6 Async reset mid-MEM_WAIT: drop rst_i between edges
//     -> outputs 0 immediately; after release Freeze_o=0 and counters 0.
//     -> With HAZARD_PERF_CNT_EN: StallCnt_o counts test 4 as 3.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage core: load-use bubble, branch flush, memory freeze.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic             IDEX_MemRead_i,
  input  logic             Branch_i,
  input  logic             Jump_i,
  input  logic             DmemReq_i,
  input  logic             DmemAck_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             Freeze_o,
  output logic             MemTimeout_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       tmo_q, tmo_d;
  logic       lu, mwait, tmo_hit, freeze;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StRun;
      wcnt_q  <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    lu      = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
              ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));
    mwait   = (state_q == StMemWait) || (DmemReq_i && !DmemAck_i);
    tmo_hit = (state_q == StMemWait) && !DmemAck_i && (wcnt_q == TimeoutVal);
    // The timeout cycle itself releases the freeze so the stuck access drains.
    freeze  = mwait && !DmemAck_i && !tmo_hit;

    state_d = state_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      StRun: begin
        if (DmemReq_i && !DmemAck_i) begin
          state_d = StMemWait;
          wcnt_d  = 8'd1;
        end
      end
      StMemWait: begin
        if (DmemAck_i) begin
          state_d = StRun;
          wcnt_d  = 8'd0;
        end else if (tmo_hit) begin
          state_d = StRun;
          wcnt_d  = 8'd0;
          tmo_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StRun;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  // Every control output is forced low while reset is held, including the write enables.
  always_comb begin
    PCWrite_o    = 1'b0;
    IFIDWrite_o  = 1'b0;
    IFIDFlush_o  = 1'b0;
    IDEXBubble_o = 1'b0;
    Freeze_o     = 1'b0;
    if (rst_i) begin
      Freeze_o     = freeze;
      PCWrite_o    = !freeze && !lu;
      IFIDWrite_o  = !freeze && !lu;
      IDEXBubble_o = !freeze && lu;
      IFIDFlush_o  = !freeze && !lu && (Branch_i || Jump_i);
    end
  end

  assign MemTimeout_o = tmo_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((Freeze_o || IDEXBubble_o) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (IFIDFlush_o && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`else
  assign StallCnt_o = '0;
  assign FlushCnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a cycle-level reference model pushes expectations,
// a negedge monitor pops and compares. Honours HAZARD_PERF_CNT_EN for the counter outputs.
module tb_hazard_stall_ctrl;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic [4:0]      ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
  logic            idex_mr = 1'b0, branch = 1'b0, jump = 1'b0, req = 1'b0, ack = 1'b0;
  logic            pcw, ifidw, flush, bubble, freeze, mtmo;
  logic [CntW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MEM_TIMEOUT(MemTimeout), .CNT_W(CntW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .IFID_Rs_i     (ifid_rs),
    .IFID_Rt_i     (ifid_rt),
    .IDEX_Rt_i     (idex_rt),
    .IDEX_MemRead_i(idex_mr),
    .Branch_i      (branch),
    .Jump_i        (jump),
    .DmemReq_i     (req),
    .DmemAck_i     (ack),
    .PCWrite_o     (pcw),
    .IFIDWrite_o   (ifidw),
    .IFIDFlush_o   (flush),
    .IDEXBubble_o  (bubble),
    .Freeze_o      (freeze),
    .MemTimeout_o  (mtmo),
    .StallCnt_o    (stall_cnt),
    .FlushCnt_o    (flush_cnt)
  );

  typedef struct packed {
    logic pcw, ifidw, flush, bubble, freeze, tmo;
    logic [CntW-1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: how long the outstanding access has been waiting (0 = none), sticky flag,
  // and integer event tallies.
  int   age = 0;
  bit   tmo_seen = 0;
  int   n_stall = 0, n_flush = 0;
  int   cnt_max = (1 << CntW) - 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pcwrite", 32'(pcw), 32'(e.pcw));
      chk("ifidwrite", 32'(ifidw), 32'(e.ifidw));
      chk("ifidflush", 32'(flush), 32'(e.flush));
      chk("idexbubble", 32'(bubble), 32'(e.bubble));
      chk("freeze", 32'(freeze), 32'(e.freeze));
      chk("memtimeout", 32'(mtmo), 32'(e.tmo));
      chk("stallcnt", 32'(stall_cnt), 32'(e.sc));
      chk("flushcnt", 32'(flush_cnt), 32'(e.fc));
    end
  end

  task automatic predict();
    exp_t e;
    bit   waiting, to_now, mem_stall, hazard;
    e = '0;
    if (!rst_i) begin
      age = 0; tmo_seen = 0; n_stall = 0; n_flush = 0;
      q.push_back(e);
      return;
    end
    waiting   = age > 0;
    to_now    = waiting && !ack && (age >= MemTimeout);
    mem_stall = (waiting || req) && !ack && !to_now;
    hazard    = idex_mr && (idex_rt != 0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    e.freeze  = mem_stall;
    e.pcw     = !mem_stall && !hazard;
    e.ifidw   = !mem_stall && !hazard;
    e.bubble  = !mem_stall && hazard;
    e.flush   = !mem_stall && !hazard && (branch || jump);
    e.tmo     = tmo_seen;
    e.sc      = Perf ? CntW'(n_stall) : '0;
    e.fc      = Perf ? CntW'(n_flush) : '0;
    q.push_back(e);
    if ((e.freeze || e.bubble) && n_stall < cnt_max) n_stall++;
    if (e.flush && n_flush < cnt_max) n_flush++;
    if (waiting) begin
      if (ack) age = 0;
      else if (to_now) begin age = 0; tmo_seen = 1; end
      else age++;
    end else if (req && !ack) begin
      age = 1;
    end
  endtask

  // Inputs and reset change 1 time unit after the rising edge, i.e. between edges.
  task automatic drive(input bit rst, input bit mr, input logic [4:0] irt, input logic [4:0] rs,
                       input logic [4:0] rt, input bit br, input bit jp, input bit rq,
                       input bit ak);
    @(posedge clk);
    #1;
    rst_i = rst; idex_mr = mr; idex_rt = irt; ifid_rs = rs; ifid_rt = rt;
    branch = br; jump = jp; req = rq; ack = ak;
    predict();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 8, 8, 0, 1, 0, 1, 0);
    idle(1);
    // Load-use on rs, then hazard gone
    drive(1, 1, 8, 8, 3, 0, 0, 0, 0);
    drive(1, 0, 8, 8, 3, 0, 0, 0, 0);
    // $zero never hazards
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rt
    drive(1, 1, 5, 2, 5, 0, 0, 0, 0);
    // Branch depending on a load: stall first, flush next cycle
    drive(1, 1, 9, 1, 9, 1, 0, 0, 0);
    drive(1, 0, 9, 1, 9, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    // Memory wait: three cycles low ack then ack
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
    // Request and ack in the same cycle
    drive(1, 0, 0, 0, 0, 1, 0, 1, 1);
    idle(1);
    // Freeze has priority over load-use and branch
    drive(1, 1, 4, 4, 4, 1, 1, 1, 0);
    drive(1, 1, 4, 4, 4, 1, 1, 1, 1);
    // Timeout: ack never comes
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    // Async reset mid-wait
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) != 0), $urandom_range(0, 1),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
